// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : MEM-stage access bus between the pipeline and the data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output MemRead_i, MemWrite_i, addr_i, data_i,
        input  data_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, data_i,
        output data_o, ack_o, err_o, stall_o
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Multi-cycle data memory with fixed latency, stall and ack.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    dmem_responder_if.slave  bus
);

    localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  C_CNT_LOAD = 4'(LATENCY - 1);
    localparam logic [31:0] C_DEPTH    = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        both_q, both_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic             req;
    logic             do_access;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_wr;
    logic             acc_both;
    logic             acc_bad;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;

    assign req = bus.MemRead_i | bus.MemWrite_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        both_d    = both_q;
        data_d    = data_q;
        err_d     = err_q;
        do_access = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_wr    = wr_q;
        acc_both  = both_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = bus.addr_i;
                    wdata_d = bus.data_i;
                    wr_d    = bus.MemWrite_i;
                    both_d  = bus.MemRead_i & bus.MemWrite_i;
                    // Single-cycle latency accesses straight from the bus on the accept edge.
                    if (LATENCY == 1) begin
                        acc_addr  = bus.addr_i;
                        acc_wdata = bus.data_i;
                        acc_wr    = bus.MemWrite_i;
                        acc_both  = bus.MemRead_i & bus.MemWrite_i;
                        do_access = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        cnt_d   = C_CNT_LOAD;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    do_access = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        acc_bad = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= C_DEPTH);
        mem_idx = acc_addr[2 +: IDX_W];
        mem_we  = do_access && acc_wr && !acc_bad;

        if (do_access) begin
            err_d = acc_bad | acc_both;
            if (!acc_wr) begin
                data_d = acc_bad ? 32'd0 : mem_q[mem_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // The array is never cleared; reset only suppresses an in-flight store.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            mem_q[mem_idx] <= acc_wdata;
        end
    end

    assign bus.stall_o = !rst_i && (((state_q == S_IDLE) && req) || (state_q == S_BUSY));
    assign bus.ack_o   = !rst_i && (state_q == S_DONE);
    assign bus.err_o   = bus.ack_o && err_q;
    assign bus.data_o  = data_q;

endmodule
`default_nettype wire
